// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared fixed-point widths, Q-format helper and sequencer state encoding
package plot_pkg;
  localparam int INTEGER_PART_WIDTH    = 8;
  localparam int FRACTIONAL_PART_WIDTH = 8;
  localparam int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START_PARSE,
    S_WAIT_PARSE,
    S_START_EVAL,
    S_WAIT_EVAL,
    S_WRITE_PIXEL,
    S_NEXT_COL
  } plot_state_t;

  // Floor toward -inf: an arithmetic shift drops the fraction bits.
  function automatic logic signed [NUMBER_WIDTH-1:0] q_floor_int(input logic signed [NUMBER_WIDTH-1:0] q);
    return q >>> FRACTIONAL_PART_WIDTH;
  endfunction
endpackage

// File: rtl/plot_sequencer_if.sv
// rtl/plot_sequencer_if.sv - parser, evaluator and framebuffer signals of the plot sequencer
interface plot_sequencer_if
  import plot_pkg::*;
#(
  parameter int NUMBER_WIDTH_P = NUMBER_WIDTH,
  parameter int X_WIDTH        = 10,
  parameter int Y_WIDTH        = 9
);
  logic                      parser_start;
  logic                      parser_ready;
  logic                      eval_start;
  logic [NUMBER_WIDTH_P-1:0] eval_x;
  logic                      eval_done;
  logic [NUMBER_WIDTH_P-1:0] eval_y;
  logic                      eval_error;
  logic                      pixel_we;
  logic [X_WIDTH-1:0]        pixel_x;
  logic [Y_WIDTH-1:0]        pixel_y;
  logic                      pixel_value;
  logic                      pixel_ready;

  modport master (
    output parser_start, eval_start, eval_x, pixel_we, pixel_x, pixel_y, pixel_value,
    input  parser_ready, eval_done, eval_y, eval_error, pixel_ready
  );

  modport slave (
    input  parser_start, eval_start, eval_x, pixel_we, pixel_x, pixel_y, pixel_value,
    output parser_ready, eval_done, eval_y, eval_error, pixel_ready
  );
endinterface

// File: rtl/plot_y_to_row.sv
// rtl/plot_y_to_row.sv - converts a signed Q y value into a screen row with clip detection
module plot_y_to_row #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int SCREEN_HEIGHT         = 480,
  localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic [NW-1:0] y,
  output logic [YW-1:0] row,
  output logic          in_range
);
  localparam int RW = INTEGER_PART_WIDTH + 2;
  localparam logic signed [RW-1:0] CENTRE  = RW'(SCREEN_HEIGHT / 2 - 1);
  localparam logic signed [RW-1:0] ROW_MAX = RW'(SCREEN_HEIGHT - 1);

  logic signed [INTEGER_PART_WIDTH-1:0] y_int;
  logic signed [RW-1:0]                 y_ext;
  logic signed [RW-1:0]                 row_s;
  logic                                 unused_frac;

  // Taking the integer bits of a two's-complement Q value is the floor.
  assign y_int       = y[NW-1:FRACTIONAL_PART_WIDTH];
  assign unused_frac = ^y[FRACTIONAL_PART_WIDTH-1:0];
  assign y_ext       = {{2{y_int[INTEGER_PART_WIDTH-1]}}, y_int};
  assign row_s       = CENTRE - y_ext;
  assign in_range    = !row_s[RW-1] && (row_s <= ROW_MAX);
  assign row         = row_s[YW-1:0];
endmodule

// File: rtl/plot_sequencer.sv
// rtl/plot_sequencer.sv - clears the framebuffer, runs the parser, then plots one pixel per column
// Optional watchdog on the parser/evaluator waits: PLOT_SEQUENCER_TIMEOUT_EN.
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int SCREEN_WIDTH          = 640,
  parameter int SCREEN_HEIGHT         = 480,
  parameter logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] X_START = 16'hEC00,
  parameter logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] X_STEP  = 16'h0010
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef PLOT_SEQUENCER_TIMEOUT_EN
  output logic timeout,
`endif
  plot_sequencer_if.master bus
);
  localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam logic [XW-1:0] COL_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(SCREEN_HEIGHT - 1);

  plot_state_t   state, state_nx;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [NW-1:0] x_acc;
  logic          done_r;
  logic [YW-1:0] calc_row;
  logic          calc_in_range;
  logic          accept;

  plot_y_to_row #(
    .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
    .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH),
    .SCREEN_HEIGHT        (SCREEN_HEIGHT)
  ) u_y_to_row (
    .y       (bus.eval_y),
    .row     (calc_row),
    .in_range(calc_in_range)
  );

`ifdef PLOT_SEQUENCER_TIMEOUT_EN
  logic [15:0] wdog;
  logic        wdog_hit;
  logic        timeout_r;

  assign wdog_hit = (wdog == 16'hFFFF);
  assign timeout  = timeout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog      <= '0;
      timeout_r <= 1'b0;
    end else begin
      if ((state == S_WAIT_PARSE || state == S_WAIT_EVAL) && state_nx == state)
        wdog <= wdog + 16'd1;
      else
        wdog <= '0;
      if (state == S_IDLE && start)
        timeout_r <= 1'b0;
      else if (state == S_WAIT_PARSE && !bus.parser_ready && wdog_hit)
        timeout_r <= 1'b1;
    end
  end
`else
  logic wdog_hit;
  assign wdog_hit = 1'b0;
`endif

  assign accept = bus.pixel_we && bus.pixel_ready;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (start) state_nx = S_CLEAR;
      S_CLEAR:       if (accept && col == COL_LAST && row == ROW_LAST) state_nx = S_START_PARSE;
      S_START_PARSE: state_nx = S_WAIT_PARSE;
      S_WAIT_PARSE: begin
        if (bus.parser_ready)  state_nx = S_START_EVAL;
        else if (wdog_hit)     state_nx = S_IDLE;
      end
      S_START_EVAL:  state_nx = S_WAIT_EVAL;
      S_WAIT_EVAL: begin
        if (bus.eval_done)
          state_nx = (!bus.eval_error && calc_in_range) ? S_WRITE_PIXEL : S_NEXT_COL;
        else if (wdog_hit)
          state_nx = S_NEXT_COL;
      end
      S_WRITE_PIXEL: if (accept) state_nx = S_NEXT_COL;
      S_NEXT_COL:    state_nx = (col == COL_LAST) ? S_IDLE : S_START_EVAL;
      default:       state_nx = S_IDLE;
    endcase
  end

  // Pixel outputs come straight from registers that only move on acceptance.
  assign busy             = (state != S_IDLE);
  assign done             = done_r;
  assign bus.parser_start = (state == S_START_PARSE);
  assign bus.eval_start   = (state == S_START_EVAL);
  assign bus.eval_x       = x_acc;
  assign bus.pixel_we     = (state == S_CLEAR) || (state == S_WRITE_PIXEL);
  assign bus.pixel_value  = (state == S_WRITE_PIXEL);
  assign bus.pixel_x      = col;
  assign bus.pixel_y      = row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      x_acc  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state_nx == S_IDLE) && (state != S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          col <= '0;
          row <= '0;
        end
        S_CLEAR: if (accept) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_WAIT_PARSE: if (bus.parser_ready) begin
          col   <= '0;
          x_acc <= X_START;
        end
        S_WAIT_EVAL: if (bus.eval_done && !bus.eval_error) row <= calc_row;
        S_NEXT_COL: if (col != COL_LAST) begin
          col   <= col + 1'b1;
          x_acc <= x_acc + X_STEP;
        end
        default: ;
      endcase
    end
  end
endmodule
